// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, instruction SRAM request and the IF register feeding decode.
// Optional build macro IF_ADEF_EN: flag misaligned fetch addresses as ADEF and substitute a nop.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        fs_adef,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    assign {br_taken, br_target} = br_bus;

    logic        to_fs_valid;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        br_pend;
    logic [31:0] br_pend_target;
    logic        ibuf_valid;
    logic [31:0] ibuf;

    logic        fs_allowin;
    logic        fs_req;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    assign fs_allowin = !fs_valid || ds_allowin;
    assign fs_req     = to_fs_valid && fs_allowin;

    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend) begin
            nextpc = br_pend_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid    <= 1'b0;
            fs_valid       <= 1'b0;
            fs_pc          <= RESET_PC - 32'd4;
            br_pend        <= 1'b0;
            br_pend_target <= '0;
            ibuf_valid     <= 1'b0;
        end else begin
            to_fs_valid <= 1'b1;
            if (fs_req) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
                br_pend  <= 1'b0;
            end else if (br_taken && !fs_allowin) begin
                // Wrong-path instruction is dropped; the target is fetched once IF frees up.
                fs_valid       <= 1'b0;
                br_pend        <= 1'b1;
                br_pend_target <= br_target;
            end
            if (fs_req) begin
                ibuf_valid <= 1'b0;
            end else if (fs_valid && !ds_allowin && !ibuf_valid) begin
                ibuf_valid <= 1'b1;
            end
        end
    end

    // NOTE: ibuf carries data only and is never read unless ibuf_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fs_valid && !ds_allowin && !ibuf_valid) begin
            ibuf <= inst_sram_rdata;
        end
    end

`ifdef IF_ADEF_EN
    localparam logic [31:0] NOP_INST = 32'h03400000;

    logic misaligned;
    logic fs_adef_q;

    assign misaligned = |nextpc[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_adef_q <= 1'b0;
        end else if (fs_req) begin
            fs_adef_q <= misaligned;
        end
    end

    assign inst_sram_en   = fs_req && !misaligned;
    assign inst_sram_addr = nextpc;
    assign fs_adef        = fs_adef_q;
    assign fs_inst        = fs_adef_q ? NOP_INST : (ibuf_valid ? ibuf : inst_sram_rdata);
`else
    assign inst_sram_en   = fs_req;
    assign inst_sram_addr = {nextpc[31:2], 2'b00};
    assign fs_adef        = 1'b0;
    assign fs_inst        = ibuf_valid ? ibuf : inst_sram_rdata;
`endif

    assign inst_sram_we    = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign fs_to_ds_valid  = fs_valid && !br_taken;
    assign fs_to_ds_bus    = {fs_inst, fs_pc};

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch/stall/redirect steps, then random traffic
// compared against a slot-level reference model and a deterministic SRAM content function.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP_INST = 32'h03400000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        fs_adef;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .fs_adef        (fs_adef),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the instruction slot in IF, the pending redirect, and the last fetch address.
    bit          m_started;
    bit          m_valid;
    bit          m_adef;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_pend_t;

    // SRAM environment state and per-cycle observations.
    bit          prev_en;
    logic [31:0] prev_addr;
    logic        o_en;
    logic [31:0] o_addr;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_adef;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c5a96e1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_valid   = 1'b0;
        m_adef    = 1'b0;
        m_pend    = 1'b0;
        m_pc      = RESET_PC - 32'd4;
        m_pend_t  = '0;
        prev_en   = 1'b0;
        prev_addr = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input bit allow, input bit br, input logic [31:0] tgt);
        logic [31:0] nxt;
        logic [31:0] exp_inst;
        bit          acc;
        bit          req;
        inst_sram_rdata = prev_en ? mem_word(prev_addr) : $urandom;
        ds_allowin      = allow;
        br_bus          = {br, tgt};
        @(negedge clk);
        nxt = br ? tgt : (m_pend ? m_pend_t : m_pc + 32'd4);
        acc = !m_valid || allow;
        req = m_started && acc;
        o_en    = inst_sram_en;
        o_addr  = inst_sram_addr;
        o_valid = fs_to_ds_valid;
        o_pc    = fs_to_ds_bus[31:0];
        o_inst  = fs_to_ds_bus[63:32];
        o_adef  = fs_adef;
`ifdef IF_ADEF_EN
        check("sram_en", 64'(o_en), 64'(req && (nxt[1:0] == 2'b00)));
        check("sram_addr", 64'(o_addr), 64'(nxt));
        exp_inst = m_adef ? NOP_INST : mem_word(m_pc);
`else
        check("sram_en", 64'(o_en), 64'(req));
        check("sram_addr", 64'(o_addr), 64'({nxt[31:2], 2'b00}));
        exp_inst = mem_word({m_pc[31:2], 2'b00});
`endif
        check("to_ds_valid", 64'(o_valid), 64'(m_valid && !br));
        if (m_valid && !br) begin
            check("to_ds_bus", fs_to_ds_bus, {exp_inst, m_pc});
            check("adef", 64'(o_adef), 64'(m_adef));
        end
        prev_en   = inst_sram_en;
        prev_addr = inst_sram_addr;
        if (req) begin
            m_valid = 1'b1;
            m_pc    = nxt;
            m_pend  = 1'b0;
`ifdef IF_ADEF_EN
            m_adef  = (nxt[1:0] != 2'b00);
`endif
        end else if (br && !acc) begin
            m_valid  = 1'b0;
            m_pend   = 1'b1;
            m_pend_t = tgt;
        end
        m_started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(fs_to_ds_valid), 64'd0);
        check({tag, "_en"}, 64'(inst_sram_en), 64'd0);
        check({tag, "_adef"}, 64'(fs_adef), 64'd0);
        check({tag, "_addr"}, 64'(inst_sram_addr), 64'(RESET_PC));
    endtask

    initial begin
        logic [31:0] tgt;
        resetn          = 1'b0;
        ds_allowin      = 1'b1;
        br_bus          = '0;
        inst_sram_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("sram_we", 64'(inst_sram_we), 64'd0);
        check("sram_wdata", 64'(inst_sram_wdata), 64'd0);
        resetn = 1'b1;

        // Reset release and back-to-back fetch.
        cycle(1'b1, 1'b0, 32'h0);
        check("first_cycle_idle", 64'(o_en), 64'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("first_req_addr", 64'({o_en, o_addr}), 64'({1'b1, 32'h1c000000}));
        cycle(1'b1, 1'b0, 32'h0);
        check("pc0", 64'({o_valid, o_pc}), 64'({1'b1, 32'h1c000000}));
        cycle(1'b1, 1'b0, 32'h0);
        check("pc1", 64'({o_valid, o_pc}), 64'({1'b1, 32'h1c000004}));

        // Three-cycle decode stall with garbage on the SRAM after the first cycle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("stall_hold", {o_inst, o_pc}, {mem_word(32'h1c000008), 32'h1c000008});
            check("stall_no_req", 64'(o_en), 64'd0);
        end
        cycle(1'b1, 1'b0, 32'h0);
        check("stall_release", 64'({o_en, o_addr}), 64'({1'b1, 32'h1c00000c}));
        cycle(1'b1, 1'b0, 32'h0);

        // Redirect with decode accepting.
        cycle(1'b1, 1'b1, 32'h1c000100);
        check("redir_cancel", 64'({o_valid, o_addr}), 64'({1'b0, 32'h1c000100}));

        // Redirect while decode stalls.
        cycle(1'b0, 1'b1, 32'h1c000200);
        check("redir_stall_cancel", 64'({o_valid, o_en}), 64'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("redir_pend_req", 64'({o_en, o_addr}), 64'({1'b1, 32'h1c000200}));

        // Two consecutive redirects while stalled: only the later target is fetched.
        cycle(1'b0, 1'b1, 32'h1c000300);
        cycle(1'b0, 1'b1, 32'h1c000400);
        check("double_redir_req", 64'({o_en, o_addr}), 64'({1'b1, 32'h1c000400}));
        cycle(1'b1, 1'b0, 32'h0);
        check("double_redir_pc", 64'({o_valid, o_pc}), 64'({1'b1, 32'h1c000400}));

        // Misaligned redirect target.
        cycle(1'b1, 1'b1, 32'h1c000102);
`ifdef IF_ADEF_EN
        check("misalign_no_req", 64'(o_en), 64'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("misalign_adef", 64'({o_adef, o_inst}), 64'({1'b1, NOP_INST}));
`else
        check("misalign_addr", 64'(o_addr), 64'(32'h1c000100));
        cycle(1'b1, 1'b0, 32'h0);
        check("misalign_adef", 64'(o_adef), 64'd0);
`endif
        cycle(1'b1, 1'b1, 32'h1c000500);
        cycle(1'b1, 1'b0, 32'h0);

        // Random traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2;
                resetn = 1'b0;
                br_bus = '0;
                #1;
                check_reset_outputs("midreset");
                model_reset();
                @(posedge clk);
                #1;
                resetn = 1'b1;
            end
            tgt = RESET_PC | ($urandom & 32'h0000fffc);
            if ($urandom_range(0, 9) == 0) begin
                tgt[1:0] = 2'($urandom_range(1, 3));
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the pipelined LoongArch CPU. It generates the next PC and drives the instruction SRAM port. It holds one fetched instruction in the IF register and hands `{inst, pc}` to the decode stage through a valid/allowin handshake. Branch redirects from decode arrive on `br_bus`; the block cancels wrong-path fetches and holds fetched data while decode stalls.

## Interface
- `RESET_PC`, default 32'h1c000000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `ds_allowin`  in  1  decode can accept an instruction this cycle.
- `br_bus`  in  33  `{br_taken, br_target[31:0]}`; `br_taken` is a single-cycle pulse from decode.
- `fs_to_ds_valid`  out  1  `fs_to_ds_bus` holds a live instruction.
- `fs_to_ds_bus`  out  64  `{fs_inst[31:0], fs_pc[31:0]}`.
- `fs_adef`  out  1  fetch-address-error flag that travels with the bus.
- `inst_sram_en`  out  1  read enable.
- `inst_sram_we`  out  4  constant 4'h0.
- `inst_sram_addr`  out  32  read address.
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_rdata`  in  32  read data, valid one cycle after an enabled request.

## Operation
- `to_fs_valid` register: reset 0; set to 1 on the first clock edge after `resetn` rises; stays 1.
- `fs_ready_go` = 1.
- `fs_allowin` = `!fs_valid || ds_allowin`.
- `nextpc` priority:
  - `br_taken`: `br_target`.
  - else `br_pend`: `br_pend_target`.
  - else `fs_pc + 4` (32-bit wrap, no carry out).
- `inst_sram_en` = `to_fs_valid && fs_allowin`; `inst_sram_addr` = `nextpc`.
- On an edge with `inst_sram_en`:
  - `fs_valid` <= 1.
  - `fs_pc` <= `nextpc`.
  - `br_pend` <= 0.
  - `ibuf_valid` <= 0.
- On an edge with `br_taken && !fs_allowin`:
  - `fs_valid` <= 0 (wrong-path instruction dropped).
  - `br_pend` <= 1, `br_pend_target` <= `br_target`.
  - A newer `br_taken` overwrites a pending target.
- `fs_to_ds_valid` = `fs_valid && !br_taken`. An instruction in IF on the redirect cycle never reaches decode.
- Instruction buffer:
  - On an edge with `fs_valid && !ds_allowin && !ibuf_valid`: capture `inst_sram_rdata` into `ibuf`, set `ibuf_valid`.
  - `fs_inst` = `ibuf_valid ? ibuf : inst_sram_rdata`.
- Register reset values:
  - `fs_pc` = `RESET_PC - 4`, so `nextpc` = `RESET_PC`.
  - `fs_valid`, `br_pend`, `ibuf_valid`, `to_fs_valid` = 0.
- Output values while in reset:
  - `fs_to_ds_valid` = 0, `inst_sram_en` = 0, `fs_adef` = 0.
  - `inst_sram_addr` = `RESET_PC`.
- Reset asserted mid-operation clears all state at once. No partial fetch survives.

## Timing
- Request in cycle N → `fs_to_ds_valid` = 1 in cycle N+1, with `fs_inst` = that cycle's `inst_sram_rdata`.
- Transfer to decode happens on an edge where `fs_to_ds_valid && ds_allowin`.
- Steady state with no stalls: one instruction per cycle.
- Redirect while `fs_allowin` = 1: target requested in the same cycle, zero bubbles beyond the cancelled slot.
- Redirect while `fs_allowin` = 0: one extra bubble. The target is requested in cycle N+1 from `br_pend`.
- Stall of any length: `fs_pc` and `fs_inst` stay stable. `inst_sram_en` stays 0 throughout.

## Configuration
- `IF_ADEF_EN` defined:
  - When `nextpc[1:0]` != 0, the request still advances `fs_pc` and `fs_valid`.
  - `inst_sram_en` is forced to 0 for that request.
  - `fs_adef` = 1 for that instruction.
  - `fs_inst` = 32'h03400000 (nop) for that instruction.
  - `fs_adef` clears on the next accepted fetch.
- `IF_ADEF_EN` undefined:
  - `inst_sram_addr[1:0]` forced to 2'b00.
  - `fs_adef` tied to 0.
  - No misalignment check.

## Test plan
- Reset release, `ds_allowin` = 1 → first `inst_sram_en` with addr 0x1c000000. `fs_to_ds_bus` then carries pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles.
- `ds_allowin` low for 3 cycles while pc 0x1c000008 is in IF; SRAM model drives garbage after cycle 1 → `fs_to_ds_bus` holds the original inst and pc 0x1c000008; `inst_sram_en` = 0 for 3 cycles; pc 0x1c00000c is fetched after release.
- `br_taken` with target 0x1c000100 while `ds_allowin` = 1, pc 0x1c000010 in IF → that cycle `fs_to_ds_valid` = 0, addr = 0x1c000100; next cycle the bus pc is 0x1c000100.
- `br_taken` with target 0x1c000200 while `ds_allowin` = 0 → IF emptied; next cycle request addr 0x1c000200; the wrong-path pc is never presented valid.
- Two `br_taken` pulses on consecutive stalled cycles (0x1c000300, then 0x1c000400) → only 0x1c000400 is fetched.
- With `IF_ADEF_EN`, target 0x1c000102 → `fs_adef` = 1, `fs_inst` = 0x03400000, `inst_sram_en` = 0. Without the macro → addr 0x1c000100, `fs_adef` = 0.
